// File: rtl/i_decode_pkg.sv
// ============================================================================
// Module : i_decode_pkg
// Brief  : Opcodes, control-bundle widths and per-opcode control encodings
//          shared by the decode, execute and later pipeline stages.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i_decode_pkg;

  localparam int ADDR_W = 5;
  localparam int WB_W   = 2;
  localparam int M_W    = 3;
  localparam int EX_W   = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // wb = {RegWrite, MemtoReg}, m = {Branch, MemRead, MemWrite},
  // ex = {RegDst, ALUOp[1:0], ALUSrc}
  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctl_t;

  localparam ctl_t CTL_RTYPE = ctl_t'({2'b10, 3'b000, 4'b1100});
  localparam ctl_t CTL_LW    = ctl_t'({2'b11, 3'b010, 4'b0001});
  localparam ctl_t CTL_SW    = ctl_t'({2'b00, 3'b001, 4'b0001});
  localparam ctl_t CTL_BEQ   = ctl_t'({2'b00, 3'b100, 4'b0010});
  localparam ctl_t CTL_NOP   = ctl_t'('0);

  function automatic ctl_t decode_ctl(input logic [5:0] opcode);
    ctl_t ctl;
    case (opcode)
      OP_RTYPE: ctl = CTL_RTYPE;
      OP_LW:    ctl = CTL_LW;
      OP_SW:    ctl = CTL_SW;
      OP_BEQ:   ctl = CTL_BEQ;
      default:  ctl = CTL_NOP;
    endcase
    return ctl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i_decode_reg_file.sv
// ============================================================================
// Module : i_decode_reg_file
// Brief  : 2-read / 1-write register file, r0 hardwired to zero,
//          asynchronous active-low clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i_decode_reg_file
  import i_decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
  assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];

endmodule

`default_nettype wire

// File: rtl/i_decode.sv
// ============================================================================
// Module : i_decode
// Brief  : Instruction-decode stage with register file, control decode,
//          sign extension, write-through bypass and the ID/EX latch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i_decode
  import i_decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_id_instr,
  input  logic [31:0]       if_id_npc,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic [31:0]       npc,
  output logic [DATA_W-1:0] reg_rs,
  output logic [DATA_W-1:0] reg_rt,
  output logic [DATA_W-1:0] sign_ext,
  output logic [WB_W-1:0]   wb_ctl,
  output logic [M_W-1:0]    m_ctl,
  output logic [EX_W-1:0]   ex_ctl,
  output logic [ADDR_W-1:0] instr_20_16,
  output logic [ADDR_W-1:0] instr_15_11
);

  logic [5:0]        w_opcode;
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_rd;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_rf_rs;
  logic [DATA_W-1:0] w_rf_rt;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [DATA_W-1:0] w_sign_ext;
  logic              w_wb_live;
  ctl_t              w_ctl;

  assign w_opcode = if_id_instr[31:26];
  assign w_rs     = if_id_instr[25:21];
  assign w_rt     = if_id_instr[20:16];
  assign w_rd     = if_id_instr[15:11];
  assign w_imm    = if_id_instr[15:0];

  i_decode_reg_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_reg_file (
    .clk         (clk),
    .reset       (reset),
    .i_rd_addr_a (w_rs),
    .i_rd_addr_b (w_rt),
    .o_rd_data_a (w_rf_rs),
    .o_rd_data_b (w_rf_rt),
    .i_wr_en     (wb_reg_write),
    .i_wr_addr   (wb_write_reg),
    .i_wr_data   (wb_write_data)
  );

  // Same-cycle WB write lands in the array only at the edge, so forward it.
  assign w_wb_live = wb_reg_write && (wb_write_reg != '0);
  assign w_rs_data = (w_wb_live && (wb_write_reg == w_rs)) ? wb_write_data : w_rf_rs;
  assign w_rt_data = (w_wb_live && (wb_write_reg == w_rt)) ? wb_write_data : w_rf_rt;

  assign w_sign_ext = {{(DATA_W-16){w_imm[15]}}, w_imm};
  assign w_ctl      = decode_ctl(w_opcode);

  // Flush overrides stall: a bubble is loaded even when the stage is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      npc         <= '0;
      reg_rs      <= '0;
      reg_rt      <= '0;
      sign_ext    <= '0;
      wb_ctl      <= '0;
      m_ctl       <= '0;
      ex_ctl      <= '0;
      instr_20_16 <= '0;
      instr_15_11 <= '0;
    end else if (flush || !stall) begin
      npc         <= if_id_npc;
      reg_rs      <= w_rs_data;
      reg_rt      <= w_rt_data;
      sign_ext    <= w_sign_ext;
      instr_20_16 <= w_rt;
      instr_15_11 <= w_rd;
      wb_ctl      <= flush ? '0 : w_ctl.wb;
      m_ctl       <= flush ? '0 : w_ctl.m;
      ex_ctl      <= flush ? '0 : w_ctl.ex;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i_decode.sv
// ============================================================================
// Module : tb_i_decode
// Brief  : Directed and random self-checking bench for i_decode.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_id_instr = '0;
  logic [31:0] if_id_npc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_write_reg = '0;
  logic [31:0] wb_write_data = '0;
  logic [31:0] npc, reg_rs, reg_rt, sign_ext;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic [3:0]  ex_ctl;
  logic [4:0]  instr_20_16, instr_15_11;

  int errors = 0;
  int checks = 0;

  // Reference state: architectural register contents and expected latch.
  logic [31:0] m_rf [32];
  logic [31:0] e_npc, e_rs, e_rt, e_se;
  logic [8:0]  e_ctl;
  logic [4:0]  e_i20, e_i15;

  always #5 clk = ~clk;

  i_decode dut (
    .clk           (clk),
    .reset         (reset),
    .if_id_instr   (if_id_instr),
    .if_id_npc     (if_id_npc),
    .stall         (stall),
    .flush         (flush),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .npc           (npc),
    .reg_rs        (reg_rs),
    .reg_rt        (reg_rt),
    .sign_ext      (sign_ext),
    .wb_ctl        (wb_ctl),
    .m_ctl         (m_ctl),
    .ex_ctl        (ex_ctl),
    .instr_20_16   (instr_20_16),
    .instr_15_11   (instr_15_11)
  );

  // {wb[1:0], m[2:0], ex[3:0]} straight from the opcode table.
  function automatic logic [8:0] ref_ctl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b00_000_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".npc"},      npc,                  e_npc);
    chk({tag, ".reg_rs"},   reg_rs,               e_rs);
    chk({tag, ".reg_rt"},   reg_rt,               e_rt);
    chk({tag, ".sign_ext"}, sign_ext,             e_se);
    chk({tag, ".ctl"},      {23'd0, wb_ctl, m_ctl, ex_ctl}, {23'd0, e_ctl});
    chk({tag, ".rt_fld"},   {27'd0, instr_20_16}, {27'd0, e_i20});
    chk({tag, ".rd_fld"},   {27'd0, instr_15_11}, {27'd0, e_i15});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    e_npc = '0; e_rs = '0; e_rt = '0; e_se = '0;
    e_ctl = '0; e_i20 = '0; e_i15 = '0;
  endtask

  // Drive one cycle of inputs, advance the model, clock, then check.
  task automatic cyc(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                     input logic st, input logic fl,
                     input logic we, input logic [4:0] wr, input logic [31:0] wd);
    logic [4:0]  rs, rt;
    logic [31:0] rs_v, rt_v;
    rs = instr[25:21];
    rt = instr[20:16];
    if_id_instr = instr; if_id_npc = pc; stall = st; flush = fl;
    wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
    rs_v = (we && wr != 0 && wr == rs) ? wd : m_rf[rs];
    rt_v = (we && wr != 0 && wr == rt) ? wd : m_rf[rt];
    if (fl || !st) begin
      e_npc = pc; e_rs = rs_v; e_rt = rt_v;
      e_se  = {{16{instr[15]}}, instr[15:0]};
      e_i20 = rt; e_i15 = instr[15:11];
      e_ctl = fl ? 9'd0 : ref_ctl(instr[31:26]);
    end
    if (we && wr != 0) m_rf[wr] = wd;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [31:0] ri, rinstr;
    logic [5:0]  op;
    model_reset();

    // Power-on reset with an instruction already presented.
    if_id_instr = 32'h002300AA;
    #2 reset = 1'b0;
    #1 chk_all("por");
    @(posedge clk); #1;
    reset = 1'b1;

    // Populate registers, then reset mid-operation.
    cyc("pre1", 32'hFC000000, 32'h4, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11);
    cyc("pre2", 32'h00221820, 32'h8, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99);
    if_id_instr = 32'h002300AA;
    #2 reset = 1'b0;
    model_reset();
    #1 chk_all("rst_async");
    @(posedge clk); @(posedge clk); #1;
    chk_all("rst_held");
    reset = 1'b1;

    for (int r = 0; r < 32; r++) begin
      ri = r;
      cyc("rf_clear", {6'h3F, ri[4:0], ri[4:0], 16'h0}, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("rf_clear.rs_zero", reg_rs, 32'h0);
    end

    // R-type read of r1/r3.
    cyc("wr_r1", 32'hFC000000, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5);
    cyc("wr_r3", 32'hFC000000, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd7);
    cyc("rtype", 32'h002300AA, 32'h104, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("rtype.rs5", reg_rs, 32'd5);
    chk("rtype.rt7", reg_rt, 32'd7);
    chk("rtype.ctl", {23'd0, wb_ctl, m_ctl, ex_ctl}, {23'd0, 9'b10_000_1100});

    // Load/store with positive and negative immediates.
    cyc("lw", 32'h8C123456, 32'h108, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("lw.se", sign_ext, 32'h00003456);
    cyc("sw", 32'hAD658321, 32'h10C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("sw.se", sign_ext, 32'hFFFF8321);

    // beq with same-cycle write-back to rs.
    cyc("beq_byp", 32'h10654321, 32'h110, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
    chk("beq_byp.rs", reg_rs, 32'hDEADBEEF);

    // r0 stays zero, including the bypass path.
    cyc("r0_wr", 32'h00000020, 32'h114, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    cyc("r0_rd", 32'h00001020, 32'h118, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("r0_rd.rs", reg_rs, 32'h0);

    // Stall holds outputs while the register file still takes writes.
    cyc("pre_stall", 32'h00A31020, 32'h11C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cyc("stall1", 32'h8CA40010, 32'h120, 1'b1, 1'b0, 1'b1, 5'd5, 32'd123);
    cyc("stall2", 32'hACA40020, 32'h124, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    cyc("post_stall", 32'h00A01020, 32'h128, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("post_stall.r5", reg_rs, 32'd123);

    // Flush, flush+stall and unknown opcode give zero controls.
    cyc("flush_lw", 32'h8C123456, 32'h12C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    cyc("flush_stall", 32'h00230020, 32'h130, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    cyc("op3f", 32'hFC2300AA, 32'h134, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("op3f.ctl", {23'd0, wb_ctl, m_ctl, ex_ctl}, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: op = 6'($urandom);
      endcase
      rinstr = {op, 26'($urandom)};
      cyc("rand", rinstr, $urandom,
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 1) == 1), 5'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
